multicycle_fsm: RTL and testbench
=================================

MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-002 op  in  7  opcode of the instruction register (IR).
REQ-003 funct3  in  3  IR[14:12].
REQ-004 funct7  in  1  IR[30].
REQ-005 flags  in  4  ALU flags {N,Z,C,V} = flags[3:0], valid in the same cycle as the ALU inputs.
REQ-006 mem_ready  in  1  the unified memory completes the current access this cycle.
REQ-007 Write-enable outputs:
- PCWrite  out  1  PC register load enable.
- IRWrite  out  1  loads IR and OldPC.
- MemWrite  out  1  memory store strobe.
- RegWrite  out  1  register file write.
REQ-008 Select outputs:
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- ALUSrcA  out  2  ALU operand A: 00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB  out  2  ALU operand B: 00=rs2, 01=imm, 10=constant 4.
- ResultSrc  out  2  result bus: 00=ALUOut, 01=mem data, 10=ALU result.
REQ-009 Decode outputs:
- ImmSrc  out  2  immediate format: 00=I, 01=S/B, 10=U, 11=J.
- ALUControl  out  4  ALU operation, encoded {funct7,funct3}; 4'h0=add, 4'h8=sub.
REQ-010 Status outputs:
- illegal  out  1  sticky illegal-opcode flag.
- retired  out  32  count of completed instructions.

Function
REQ-011 The state register SHALL hold one of these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT.
REQ-012 All outputs except retired SHALL be combinational decodes of state and inputs; any output a state does not name SHALL be 0.
REQ-013 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, and IRWrite=PCWrite=mem_ready.
REQ-014 FETCH SHALL stay in FETCH while mem_ready=0 and SHALL go to DECODE on mem_ready=1.
REQ-015 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add, so that ALUOut captures the branch/jump target.
REQ-016 DECODE SHALL go to:
- MEMADR for op 0000011 or 0100011;
- EXECR for 0110011;
- EXECI for 0010011;
- BRANCH for 1100011;
- JAL for 1101111;
- LUI for 0110111;
- HALT for any other op, including jalr and auipc.
REQ-017 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add, and go to MEMREAD for a load or MEMWRITE for a store.
REQ-018 MEMREAD SHALL drive AdrSrc=1, stay while mem_ready=0, and go to MEMWB on mem_ready=1.
REQ-019 MEMWB SHALL drive ResultSrc=01, RegWrite=1, and go to FETCH.
REQ-020 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, and hold MemWrite=1 until mem_ready=1, then go to FETCH.
REQ-021 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUControl={funct7,funct3}, and go to ALUWB.
REQ-022 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, with ALUControl={funct7,funct3} when funct3 is 1 or 5 and {0,funct3} otherwise, and go to ALUWB.
REQ-023 ALUWB SHALL drive ResultSrc=00, RegWrite=1, and go to FETCH.
REQ-024 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUControl=4'h8, ResultSrc=00, and go to FETCH.
REQ-025 In BRANCH, PCWrite SHALL equal the taken condition:
- beq: Z
- bne: !Z
- blt: N^V
- bge: !(N^V)
- bltu: !C
- bgeu: C
- funct3 2 or 3: 0.
REQ-026 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, and go to ALUWB, which writes rd with OldPC+4.
REQ-027 LUI SHALL drive ALUSrcA=11, ALUSrcB=01, add, and go to ALUWB.
REQ-028 ImmSrc SHALL decode from op in every state: I/load=00, S=01, B=01, U=10, J=11, others=00.
REQ-029 HALT SHALL assert illegal=1, hold all write enables at 0, and remain in HALT until reset.
REQ-030 retired SHALL increment by 1, wrapping at 2^32, on every clock edge that leaves MEMWB, MEMWRITE (with mem_ready=1), ALUWB, or BRANCH.
REQ-031 Minimum latency (cycles, with mem_ready=1) SHALL be: R/I/lui 4, load 5, store 4, branch 3, jal 4.

Reset
REQ-032 While rst_n=0, the block SHALL immediately force state=FETCH, retired=0, and illegal=0, independent of clk.
REQ-033 While in reset, write enables SHALL read 0 when mem_ready=0.
REQ-034 A reset asserted mid-instruction SHALL abandon that instruction with no further write strobes.

Verification
REQ-035 add x3,x1,x2 with mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; retired 0->1.
REQ-036 lw with mem_ready low for 3 cycles in MEMREAD -> FSM holds in MEMREAD for 3 cycles; MEMWB follows; total 8 cycles.
REQ-037 bne with flags=4'b0100 -> PCWrite=0 in BRANCH; with flags=4'b0000 -> PCWrite=1.
REQ-038 sw with mem_ready=0 for 2 cycles -> MemWrite high for 3 consecutive cycles, then FETCH.
REQ-039 op=7'b1100111 -> HALT; illegal=1; no further PCWrite/RegWrite; rst_n pulse -> FETCH, illegal=0.
REQ-040 rst_n deasserted during EXECR -> next state FETCH; RegWrite never asserted; retired unchanged at 0.

Source files
------------

// File: rtl/multicycle_fsm.sv
// multicycle_fsm: control unit for a multicycle RV32 subset core with a unified memory.
// Sequences fetch/decode/execute phases and counts retired instructions.
module multicycle_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic [3:0]  flags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        illegal,
    output logic [31:0] retired
);
    localparam logic [6:0] OP_L = 7'b0000011, OP_S = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        taken, retire;

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 4'h0;
        illegal    = 1'b0;
        ImmSrc     = (op == OP_S || op == OP_B) ? 2'b01 : op == OP_LUI ? 2'b10 :
                     op == OP_JAL ? 2'b11 : 2'b00;
        // funct3[0] inverts each base condition (eq/lt/ltu); funct3 2,3 never branch
        taken      = funct3[2] ? (funct3[1] ? flags[1] == funct3[0] : (flags[3] ^ flags[0]) != funct3[0])
                               : (!funct3[1] && flags[2] != funct3[0]);
        retire     = state_q == MEMWB || state_q == ALUWB || state_q == BRANCH ||
                     (state_q == MEMWRITE && mem_ready);
        retired_d  = retired_q + {31'd0, retire};
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = (op == OP_L || op == OP_S) ? MEMADR : op == OP_R ? EXECR :
                          op == OP_I ? EXECI : op == OP_B ? BRANCH : op == OP_JAL ? JAL :
                          op == OP_LUI ? LUI : HALT;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op == OP_L ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = {funct7, funct3};
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = {funct7 && funct3[1:0] == 2'b01, funct3};
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 4'h8;
                PCWrite    = taken;
                state_d    = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = ALUWB;
            end
            HALT: illegal = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_fsm.sv
// tb_multicycle_fsm: instruction-level phase model checked against the control outputs every cycle,
// plus literal checks on write-strobe counts, branch decisions, halt and reset behaviour.
module tb_multicycle_fsm;
    logic        clk = 1'b0, rst_n = 1'b0, funct7 = 1'b0, mem_ready = 1'b0;
    logic [6:0]  op = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [3:0]  flags = 4'd0;
    logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0]  ALUControl;
    logic [31:0] retired;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR,
                  P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_LUI, P_HALT} phase_t;

    phase_t      exp_phase = P_FETCH;
    logic [31:0] exp_ret = 0;
    int          n_cmp = 0, n_bad = 0, rw_cnt = 0, mw_cnt = 0;
    logic        br_pc = 1'b0;

    multicycle_fsm dut (.clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .flags(flags), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .illegal(illegal), .retired(retired));

    always #5 clk = ~clk;

    // Expected control word for a phase, taken straight from the per-phase output table
    function automatic logic [17:0] model(phase_t p, logic [6:0] o, logic [2:0] f3, logic f7,
                                          logic [3:0] fl, logic mr);
        logic pcw = 0, irw = 0, mw = 0, rw = 0, adr = 0, ill = 0;
        logic [1:0] a = 0, b = 0, rs = 0, imm;
        logic [3:0] alu = 0;
        logic [7:0] tk;
        imm = (o == 7'b0100011 || o == 7'b1100011) ? 2'd1 : o == 7'b0110111 ? 2'd2 :
              o == 7'b1101111 ? 2'd3 : 2'd0;
        tk = {fl[1], !fl[1], !(fl[3] ^ fl[0]), fl[3] ^ fl[0], 1'b0, 1'b0, !fl[2], fl[2]};
        case (p)
            P_FETCH:    begin b = 2; rs = 2; irw = mr; pcw = mr; end
            P_DECODE:   begin a = 1; b = 1; end
            P_MEMADR:   begin a = 2; b = 1; end
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin rs = 1; rw = 1; end
            P_MEMWRITE: begin adr = 1; mw = 1; end
            P_EXECR:    begin a = 2; alu = {f7, f3}; end
            P_EXECI:    begin a = 2; b = 1; alu = (f3 == 1 || f3 == 5) ? {f7, f3} : {1'b0, f3}; end
            P_ALUWB:    rw = 1;
            P_BRANCH:   begin a = 2; alu = 4'h8; pcw = tk[f3]; end
            P_JAL:      begin a = 1; b = 2; pcw = 1; end
            P_LUI:      begin a = 3; b = 1; end
            P_HALT:     ill = 1;
            default:    ;
        endcase
        return {pcw, irw, mw, rw, adr, a, b, rs, imm, alu, ill};
    endfunction

    always @(negedge clk) begin
        logic [17:0] e, g;
        e = model(exp_phase, op, funct3, funct7, flags, mem_ready);
        g = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
             ALUControl, illegal};
        n_cmp++;
        if (g !== e || retired !== exp_ret) begin
            n_bad++;
            $display("FAIL cycle %s t=%0t: ctrl got %h need %h, retired got %0d need %0d",
                     exp_phase.name(), $time, g, e, retired, exp_ret);
        end
        rw_cnt += int'(RegWrite);
        mw_cnt += int'(MemWrite);
        if (exp_phase == P_BRANCH) br_pc = PCWrite;
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d need %0d", name, act, req);
        end
    endtask

    task automatic step(input phase_t p, input logic mr);
        exp_phase = p;
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [3:0] fl, input int fs, input int ms);
        op = o; funct3 = f3; funct7 = f7; flags = fl;
        rw_cnt = 0; mw_cnt = 0;
        repeat (fs) step(P_FETCH, 1'b0);
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b1);
        case (o)
            7'b0000011: begin
                step(P_MEMADR, 1'b1);
                repeat (ms) step(P_MEMREAD, 1'b0);
                step(P_MEMREAD, 1'b1);
                step(P_MEMWB, 1'b1);
                exp_ret++;
            end
            7'b0100011: begin
                step(P_MEMADR, 1'b1);
                repeat (ms) step(P_MEMWRITE, 1'b0);
                step(P_MEMWRITE, 1'b1);
                exp_ret++;
            end
            7'b0110011: begin step(P_EXECR, 1'b1); step(P_ALUWB, 1'b1); exp_ret++; end
            7'b0010011: begin step(P_EXECI, 1'b1); step(P_ALUWB, 1'b1); exp_ret++; end
            7'b1100011: begin step(P_BRANCH, 1'b1); exp_ret++; end
            7'b1101111: begin step(P_JAL, 1'b1); step(P_ALUWB, 1'b1); exp_ret++; end
            7'b0110111: begin step(P_LUI, 1'b1); step(P_ALUWB, 1'b1); exp_ret++; end
            default: repeat (3) step(P_HALT, 1'b1);
        endcase
        exp_phase = P_FETCH;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_phase = P_FETCH;
        exp_ret = 0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        rst_n = 1'b1;
        lit("reset_retired", retired, 32'd0);
        run(7'b0110011, 3'd0, 1'b0, 4'd0, 0, 0);
        lit("add_regwrite_count", rw_cnt, 32'd1);
        lit("add_retired", retired, 32'd1);
        run(7'b0110011, 3'd0, 1'b1, 4'd0, 0, 0);
        run(7'b0010011, 3'd5, 1'b1, 4'd0, 0, 0);
        run(7'b0010011, 3'd0, 1'b1, 4'd0, 0, 0);
        run(7'b0110111, 3'd3, 1'b0, 4'd0, 0, 0);
        run(7'b0000011, 3'd2, 1'b0, 4'd0, 0, 3);
        lit("lw_retired", retired, 32'd6);
        run(7'b0100011, 3'd2, 1'b0, 4'd0, 0, 2);
        lit("sw_memwrite_cycles", mw_cnt, 32'd3);
        run(7'b1100011, 3'd1, 1'b0, 4'b0100, 0, 0);
        lit("bne_z1_pcwrite", {31'd0, br_pc}, 32'd0);
        run(7'b1100011, 3'd1, 1'b0, 4'b0000, 0, 0);
        lit("bne_z0_pcwrite", {31'd0, br_pc}, 32'd1);
        run(7'b1100011, 3'd4, 1'b0, 4'b1000, 0, 0);
        lit("blt_n1v0_pcwrite", {31'd0, br_pc}, 32'd1);
        for (int i = 0; i < 8; i++) run(7'b1100011, 3'(i), 1'b0, 4'(i * 5 + 3), 0, 0);
        run(7'b1100011, 3'd6, 1'b0, 4'b0010, 0, 0);
        lit("bltu_c1_pcwrite", {31'd0, br_pc}, 32'd0);
        run(7'b1101111, 3'd0, 1'b0, 4'd0, 2, 0);
        run(7'b0000011, 3'd2, 1'b0, 4'd0, 1, 0);
        run(7'b0100011, 3'd2, 1'b0, 4'd0, 0, 0);
        lit("sw_fast_memwrite_cycles", mw_cnt, 32'd1);
        run(7'b1100111, 3'd0, 1'b0, 4'd0, 0, 0);
        lit("halt_illegal", {31'd0, illegal}, 32'd1);
        lit("halt_no_writes", rw_cnt, 32'd0);
        do_reset();
        lit("reset_clears_illegal", {31'd0, illegal}, 32'd0);
        lit("reset_clears_retired", retired, 32'd0);
        rst_n = 1'b1;
        op = 7'b0110011; funct3 = 3'd0; funct7 = 1'b0; rw_cnt = 0;
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b1);
        exp_phase = P_EXECR;
        @(negedge clk);
        #1;
        do_reset();
        lit("abort_no_regwrite", rw_cnt, 32'd0);
        lit("abort_retired", retired, 32'd0);
        rst_n = 1'b1;
        run(7'b0110011, 3'd7, 1'b0, 4'd0, 0, 0);
        lit("after_abort_retired", retired, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
